// File: rtl/cache_wb_drain.sv
// Write-back drain engine: pops one {addr, line} eviction entry at a time, serialises
// the line into BUS_WIDTH write beats, then waits for one write ack before the next line.
module cache_wb_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [ADDR_WIDTH+LINE_WIDTH-1:0] fifo_data_i,
  input  logic                           fifo_empty_i,
  output logic                           fifo_pop_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [BUS_WIDTH-1:0]           mem_wdata_o,
  output logic                           mem_last_o,
  output logic                           mem_valid_o,
  input  logic                           mem_ready_i,
  input  logic                           mem_ack_i,
  input  logic                           mem_err_i,
  output logic                           busy_o,
  output logic                           err_o,
  input  logic                           err_clr_i
);

  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]         LAST_K = CW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BUS_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK
  } state_t;

  state_t                state;
  logic [CW-1:0]         beat;
  logic [LINE_WIDTH-1:0] line_sr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [LINE_WIDTH-1:0] head_line;
  logic                  ack_ok;
  logic                  err_set;
  logic                  pop;

  assign {head_addr, head_line} = fifo_data_i;

  // Acks outside WAIT_ACK are ignored entirely, including their error qualifier.
  assign ack_ok     = (state == WAIT_ACK) & mem_ack_i;
  assign err_set    = ack_ok & mem_err_i;
  assign pop        = rstn_i & ~fifo_empty_i & ((state == IDLE) | ack_ok);
  assign fifo_pop_o = pop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      beat        <= '0;
      line_sr     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_last_o  <= 1'b0;
      mem_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (err_set) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end

      case (state)
        IDLE, WAIT_ACK: begin
          if (pop) begin
            // Beat 0 is presented straight from the FIFO head; the rest is kept
            // in a shift register so each later beat is just its low slice.
            state       <= SEND;
            beat        <= '0;
            mem_addr_o  <= head_addr;
            mem_wdata_o <= head_line[BUS_WIDTH-1:0];
            line_sr     <= head_line >> BUS_WIDTH;
            mem_last_o  <= (BEATS == 1);
            mem_valid_o <= 1'b1;
            busy_o      <= 1'b1;
          end else if (ack_ok) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end

        SEND: begin
          if (mem_ready_i) begin
            if (beat == LAST_K) begin
              state       <= WAIT_ACK;
              mem_valid_o <= 1'b0;
              mem_last_o  <= 1'b0;
            end else begin
              beat        <= beat + CW'(1);
              mem_addr_o  <= mem_addr_o + STRIDE;
              mem_wdata_o <= line_sr[BUS_WIDTH-1:0];
              line_sr     <= line_sr >> BUS_WIDTH;
              mem_last_o  <= ((beat + CW'(1)) == LAST_K);
            end
          end
        end

        default: begin
          state       <= IDLE;
          mem_valid_o <= 1'b0;
          mem_last_o  <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_wb_drain.sv
// Bench for cache_wb_drain: a FIFO/beat scoreboard model checks every cycle, driven by
// a vector table, hand-written corner sequences and a randomized drain run.
module tb_cache_wb_drain;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int BW = 32;
  localparam int BEATS = LW / BW;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [AW+LW-1:0] fifo_data;
  logic fifo_empty;
  logic fifo_pop;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic mem_last, mem_valid, mem_ready, mem_ack, mem_err;
  logic busy, err, err_clr;
  logic ack_auto = 1'b0, ack_man = 1'b0, clr_man = 1'b0, clr_on_ack = 1'b0;

  assign mem_ack = ack_auto | ack_man;
  assign err_clr = clr_man | (clr_on_ack & ack_auto);

  cache_wb_drain #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BUS_WIDTH(BW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_pop_o(fifo_pop),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_last_o(mem_last),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_ack_i(mem_ack), .mem_err_i(mem_err),
    .busy_o(busy), .err_o(err), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [LW-1:0] l; } entry_t;
  typedef struct { logic [AW-1:0] a; logic [BW-1:0] d; bit l; int idx; } beat_t;
  typedef struct {
    logic [AW-1:0] a; logic [LW-1:0] l; bit e; bit c;
    logic [AW-1:0] xa; logic [BW-1:0] xd; bit xerr;
  } vec_t;

  entry_t fq[$];
  beat_t  eb[$];
  int pop_cycs[$], b0_cycs[$];
  int vec_cnt = 0, miss_cnt = 0;
  int cyc = 0, hs_total = 0, pop_total = 0;
  bit busy_m = 0, in_send = 0, awaiting = 0, err_m = 0;
  bit pop_seen = 0, last_hs = 0, stall_prev = 0, ack_pending = 0;
  int ack_wait = 0, ack_dly = 0;
  logic [AW-1:0] held_a, last_a;
  logic [BW-1:0] held_d, last_d;
  logic held_l;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_beats(entry_t e);
    for (int k = 0; k < BEATS; k++) begin
      beat_t b;
      b.a = e.a + AW'(k * (BW / 8));
      b.d = BW'(e.l >> (k * BW));
      b.l = (k == BEATS - 1);
      b.idx = k;
      eb.push_back(b);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Ack generator: acks a line ack_dly cycles after the cycle following its last beat.
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      ack_pending = 0;
      ack_auto = 1'b0;
    end else begin
      if (last_hs) begin
        ack_pending = 1;
        ack_wait = ack_dly;
      end
      ack_auto = 1'b0;
      if (ack_pending) begin
        if (ack_wait == 0) begin
          ack_auto = 1'b1;
          ack_pending = 0;
        end else ack_wait--;
      end
    end
  end

  // FIFO model: head entry presented to the DUT, removed after an observed pop.
  always @(posedge clk) begin
    #2;
    if (pop_seen && fq.size() > 0) void'(fq.pop_front());
    pop_seen = 0;
    fifo_empty = (fq.size() == 0);
    fifo_data = fifo_empty ? '0 : {fq[0].a, fq[0].l};
  end

  // Reference model and scoreboard, evaluated mid-cycle before the next commit edge.
  always @(negedge clk) begin : mon
    bit pexp, hs, acc;
    beat_t b;
    if (!rstn) begin
      busy_m = 0; in_send = 0; awaiting = 0; err_m = 0;
      pop_seen = 0; last_hs = 0; stall_prev = 0;
      eb.delete();
    end else begin
      acc  = awaiting && mem_ack;
      pexp = !fifo_empty && (!busy_m || acc);
      chk("pop", 128'(fifo_pop), 128'(pexp));
      chk("busy", 128'(busy), 128'(busy_m));
      chk("valid", 128'(mem_valid), 128'(in_send));
      chk("err", 128'(err), 128'(err_m));
      if (stall_prev && mem_valid) begin
        chk("hold_addr", 128'(mem_addr), 128'(held_a));
        chk("hold_data", 128'(mem_wdata), 128'(held_d));
        chk("hold_last", 128'(mem_last), 128'(held_l));
      end
      stall_prev = mem_valid && !mem_ready;
      held_a = mem_addr; held_d = mem_wdata; held_l = mem_last;
      hs = mem_valid && mem_ready;
      last_hs = hs && mem_last;
      if (hs) begin
        hs_total++;
        if (eb.size() == 0) chk("unexpected_beat", 128'(1), 128'(0));
        else begin
          b = eb.pop_front();
          chk("beat_addr", 128'(mem_addr), 128'(b.a));
          chk("beat_data", 128'(mem_wdata), 128'(b.d));
          chk("beat_last", 128'(mem_last), 128'(b.l));
          if (b.idx == 0) b0_cycs.push_back(cyc);
          if (b.l) begin
            in_send = 0;
            awaiting = 1;
            last_a = mem_addr;
            last_d = mem_wdata;
          end
        end
      end
      if (acc && mem_err) err_m = 1;
      else if (err_clr) err_m = 0;
      if (acc) awaiting = 0;
      if (fifo_pop && !fifo_empty) begin
        pop_seen = 1;
        pop_total++;
        pop_cycs.push_back(cyc);
      end
      if (pexp) begin
        push_beats(fq[0]);
        busy_m = 1;
        in_send = 1;
      end else if (acc) busy_m = 0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int max);
    int i;
    bit done;
    i = 0;
    done = 0;
    while (!done && i < max) begin
      step();
      i++;
      done = (fq.size() == 0) && !busy && (eb.size() == 0);
    end
    chk("drain_done", 128'(done), 128'(1));
  endtask

  task automatic wait_valid(input int max);
    int i;
    i = 0;
    while (!mem_valid && i < max) begin
      step();
      i++;
    end
    chk("valid_seen", 128'(mem_valid), 128'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 128'(mem_valid), 128'(0));
    chk({tag, "_last"}, 128'(mem_last), 128'(0));
    chk({tag, "_addr"}, 128'(mem_addr), 128'(0));
    chk({tag, "_wdata"}, 128'(mem_wdata), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_pop"}, 128'(fifo_pop), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    miss_cnt++;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    bit bp[7];
    int h0, p0;
    entry_t e;

    tbl[0] = '{32'h0000_1000, 128'h44443333_22221111_00000000_FFFFFFFF, 1'b0, 1'b0,
               32'h0000_100C, 32'h44443333, 1'b0};
    tbl[1] = '{32'hFFFF_FFF8, 128'h76543210_FEDCBA98_01234567_89ABCDEF, 1'b0, 1'b0,
               32'h0000_0004, 32'h76543210, 1'b0};
    tbl[2] = '{32'h0000_2002, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 1'b1, 1'b0,
               32'h0000_200E, 32'hDEADBEEF, 1'b1};
    tbl[3] = '{32'h0000_0000, 128'h11111111_22222222_33333333_44444444, 1'b1, 1'b1,
               32'h0000_000C, 32'h11111111, 1'b1};
    tbl[4] = '{32'h0000_0040, 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA, 1'b0, 1'b1,
               32'h0000_004C, 32'h0F0F0F0F, 1'b0};
    bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    mem_ready = 1'b0;
    mem_err = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;
    #1 rstn = 1'b0;
    #2 chk_all_zero("reset");
    step(2);
    rstn = 1'b1;
    step(2);

    // Table: single lines with ack error / clear combinations.
    mem_ready = 1'b1;
    ack_dly = 0;
    for (int i = 0; i < 5; i++) begin
      p0 = pop_total;
      mem_err = tbl[i].e;
      clr_on_ack = tbl[i].c;
      fq.push_back('{tbl[i].a, tbl[i].l});
      wait_idle(50);
      chk("tbl_last_addr", 128'(last_a), 128'(tbl[i].xa));
      chk("tbl_last_data", 128'(last_d), 128'(tbl[i].xd));
      chk("tbl_err", 128'(err), 128'(tbl[i].xerr));
      chk("tbl_pops", 128'(pop_total - p0), 128'(1));
      clr_on_ack = 1'b0;
      mem_err = 1'b0;
      step();
    end

    // Backpressure: ready toggles while beats are presented.
    mem_ready = 1'b0;
    h0 = hs_total;
    fq.push_back('{32'h0000_3000, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000});
    wait_valid(10);
    for (int i = 0; i < 7; i++) begin
      mem_ready = bp[i];
      step();
    end
    chk("bp_beats", 128'(hs_total - h0), 128'(4));
    mem_ready = 1'b1;
    wait_idle(20);
    chk("bp_beats_total", 128'(hs_total - h0), 128'(4));

    // Back-to-back: three queued lines, earliest acks.
    pop_cycs.delete();
    b0_cycs.delete();
    h0 = hs_total;
    for (int i = 0; i < 3; i++)
      fq.push_back('{32'h0000_5000 + 32'(i * 16), {4{32'(i + 32'hB0)}}});
    wait_idle(100);
    chk("b2b_beats", 128'(hs_total - h0), 128'(12));
    chk("b2b_pops", 128'(pop_cycs.size()), 128'(3));
    chk("b2b_b0s", 128'(b0_cycs.size()), 128'(3));
    if (pop_cycs.size() == 3 && b0_cycs.size() == 3) begin
      chk("b2b_gap1", 128'(pop_cycs[1] - pop_cycs[0]), 128'(5));
      chk("b2b_gap2", 128'(pop_cycs[2] - pop_cycs[1]), 128'(5));
      for (int i = 0; i < 3; i++)
        chk("b2b_pop_to_beat0", 128'(b0_cycs[i] - pop_cycs[i]), 128'(1));
    end

    // Stray acks with error in IDLE and in SEND.
    mem_ready = 1'b0;
    mem_err = 1'b1;
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    step();
    chk("stray_idle_err", 128'(err), 128'(0));
    chk("stray_idle_busy", 128'(busy), 128'(0));
    fq.push_back('{32'h0000_6000, 128'h01010101_02020202_03030303_04040404});
    wait_valid(10);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    chk("stray_send_err", 128'(err), 128'(0));
    chk("stray_send_busy", 128'(busy), 128'(1));
    chk("stray_send_valid", 128'(mem_valid), 128'(1));
    mem_err = 1'b0;
    mem_ready = 1'b1;
    wait_idle(20);

    // Reset after beat 1, then resume.
    h0 = hs_total;
    fq.push_back('{32'h0000_7000, 128'h77777777_66666666_55555555_44444444});
    for (int i = 0; i < 20 && hs_total < h0 + 2; i++) step();
    chk("pre_reset_beats", 128'(hs_total - h0), 128'(2));
    rstn = 1'b0;
    #1 chk_all_zero("midreset");
    step(2);
    rstn = 1'b1;
    p0 = pop_total;
    step(4);
    chk("post_reset_pops", 128'(pop_total - p0), 128'(0));
    chk("post_reset_valid", 128'(mem_valid), 128'(0));
    h0 = hs_total;
    fq.push_back('{32'hFFFF_FFF8, 128'h88888888_99999999_AAAAAAAA_BBBBBBBB});
    wait_idle(30);
    chk("resume_beats", 128'(hs_total - h0), 128'(4));
    chk("resume_last_addr", 128'(last_a), 128'(32'h0000_0004));

    // Randomized drain with random ready, ack delay, errors and clears.
    for (int i = 0; i < 600; i++) begin
      mem_ready = ($urandom_range(3) != 0);
      mem_err = ($urandom_range(3) == 0);
      clr_man = ($urandom_range(9) == 0);
      ack_dly = $urandom_range(3);
      if (fq.size() < 3 && $urandom_range(2) == 0) begin
        e.a = $urandom;
        e.l = {$urandom, $urandom, $urandom, $urandom};
        fq.push_back(e);
      end
      step();
    end
    clr_man = 1'b0;
    mem_ready = 1'b1;
    wait_idle(200);
    clr_man = 1'b1;
    step();
    clr_man = 1'b0;
    step();
    chk("final_clear", 128'(err), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
